// File: rtl/aes128_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes128_encrypt_core
// Purpose  : Iterative AES-128 encryption engine. One round per clock with
//            on-the-fly key expansion. A start pulse accepted in IDLE captures
//            plaintext and key. The ciphertext appears, registered, 11 cycles
//            later.
// Ports    : CLK                  - system clock, rising edge
//            RST                  - synchronous reset, active low
//            start_in             - start pulse, sampled only in IDLE
//            plaintext0..3_in     - input state columns (byte 0 in [31:24])
//            key0..3_in           - cipher key words w0..w3
//            ciphertext0..3_out   - result columns, same byte order
//            valid_out            - ciphertext outputs hold a completed result
// Revision : 1.0 - initial release
// ============================================================================
module aes128_encrypt_core (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] plaintext0_in,
  input  logic [31:0] plaintext1_in,
  input  logic [31:0] plaintext2_in,
  input  logic [31:0] plaintext3_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] ciphertext0_out,
  output logic [31:0] ciphertext1_out,
  output logic [31:0] ciphertext2_out,
  output logic [31:0] ciphertext3_out,
  output logic        valid_out
);

  // FSM encoding
  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_ROUND0    = 2'd1;
  localparam logic [1:0] c_ROUND1TO9 = 2'd2;
  localparam logic [1:0] c_ROUND10   = 2'd3;

  // AES forward S-box
  localparam logic [7:0] c_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_SBOX[x];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      // 3*a == xtime(a) ^ a
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  // Round constant for the key word produced in round r (1..10)
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]   r_fsm;
  logic [3:0]   r_round;
  logic [127:0] r_pt;
  logic [127:0] r_key;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [127:0] r_ct;
  logic         r_valid;

  // --------------------------------------------------------------------------
  // Round datapath: SubBytes + ShiftRows fused. Output byte (row R, col C)
  // takes the S-box of input byte (row R, col (C+R) mod 4).
  // --------------------------------------------------------------------------
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round_mid;
  logic [127:0] w_round_last;

  for (genvar i = 0; i < 16; i++) begin : g_sub_shift
    localparam int c_ROW = i % 4;
    localparam int c_COL = i / 4;
    localparam int c_SRC = 4 * ((c_COL + c_ROW) % 4) + c_ROW;
    assign w_sr[127-8*i -: 8] = sbox(r_state[127-8*c_SRC -: 8]);
  end

  assign w_mc = mix_columns(w_sr);

  // --------------------------------------------------------------------------
  // Key expansion: derive K_r from K_(r-1) held in r_rkey
  // --------------------------------------------------------------------------
  logic [31:0]  w_kw0, w_kw1, w_kw2, w_kw3;
  logic [31:0]  w_rot;
  logic [31:0]  w_subrot;
  logic [31:0]  w_temp;
  logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;
  logic [127:0] w_next_key;

  assign w_kw0 = r_rkey[127:96];
  assign w_kw1 = r_rkey[95:64];
  assign w_kw2 = r_rkey[63:32];
  assign w_kw3 = r_rkey[31:0];
  assign w_rot = {w_kw3[23:0], w_kw3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sub
    assign w_subrot[31-8*j -: 8] = sbox(w_rot[31-8*j -: 8]);
  end

  assign w_temp     = w_subrot ^ {rcon(r_round), 24'h000000};
  assign w_nk0      = w_kw0 ^ w_temp;
  assign w_nk1      = w_kw1 ^ w_nk0;
  assign w_nk2      = w_kw2 ^ w_nk1;
  assign w_nk3      = w_kw3 ^ w_nk2;
  assign w_next_key = {w_nk0, w_nk1, w_nk2, w_nk3};

  assign w_round_mid  = w_mc ^ w_next_key;
  assign w_round_last = w_sr ^ w_next_key;

  // --------------------------------------------------------------------------
  // Control and state update
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_fsm   <= c_IDLE;
      r_round <= 4'd0;
      r_pt    <= '0;
      r_key   <= '0;
      r_state <= '0;
      r_rkey  <= '0;
      r_ct    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_fsm)
        c_IDLE: begin
          if (start_in) begin
            // Capture operands so inputs are free to change afterwards
            r_pt    <= {plaintext0_in, plaintext1_in, plaintext2_in, plaintext3_in};
            r_key   <= {key0_in, key1_in, key2_in, key3_in};
            r_valid <= 1'b0;
            r_fsm   <= c_ROUND0;
          end
        end
        c_ROUND0: begin
          r_state <= r_pt ^ r_key;
          r_rkey  <= r_key;
          r_round <= 4'd1;
          r_fsm   <= c_ROUND1TO9;
        end
        c_ROUND1TO9: begin
          r_state <= w_round_mid;
          r_rkey  <= w_next_key;
          r_round <= r_round + 4'd1;
          if (r_round == 4'd9) begin
            r_fsm <= c_ROUND10;
          end
        end
        c_ROUND10: begin
          r_state <= w_round_last;
          r_rkey  <= w_next_key;
          r_ct    <= w_round_last;
          r_valid <= 1'b1;
          r_round <= 4'd0;
          r_fsm   <= c_IDLE;
        end
        default: begin
          r_fsm <= c_IDLE;
        end
      endcase
    end
  end

  assign ciphertext0_out = r_ct[127:96];
  assign ciphertext1_out = r_ct[95:64];
  assign ciphertext2_out = r_ct[63:32];
  assign ciphertext3_out = r_ct[31:0];
  assign valid_out       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_encrypt_core
// Purpose  : Directed self-checking bench for aes128_encrypt_core using
//            published AES-128 vectors and hand-derived timing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt_core;

  localparam logic [127:0] c_PT_A  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] c_KEY_A = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] c_R0_A  = 128'h001f0e543c4e08596e221b0b4774311a;
  localparam logic [127:0] c_RK1_A = 128'he232fcf191129188b159e4e6d679a293;
  localparam logic [127:0] c_CT_A  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] c_PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int           c_MAX_WAIT = 30;

  logic        CLK;
  logic        RST;
  logic        start_in;
  logic [31:0] plaintext0_in, plaintext1_in, plaintext2_in, plaintext3_in;
  logic [31:0] key0_in, key1_in, key2_in, key3_in;
  logic [31:0] ciphertext0_out, ciphertext1_out, ciphertext2_out, ciphertext3_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  int n;

  logic [127:0] w_ct_all;
  assign w_ct_all = {ciphertext0_out, ciphertext1_out, ciphertext2_out, ciphertext3_out};

  aes128_encrypt_core dut (
    .CLK             (CLK),
    .RST             (RST),
    .start_in        (start_in),
    .plaintext0_in   (plaintext0_in),
    .plaintext1_in   (plaintext1_in),
    .plaintext2_in   (plaintext2_in),
    .plaintext3_in   (plaintext3_in),
    .key0_in         (key0_in),
    .key1_in         (key1_in),
    .key2_in         (key2_in),
    .key3_in         (key3_in),
    .ciphertext0_out (ciphertext0_out),
    .ciphertext1_out (ciphertext1_out),
    .ciphertext2_out (ciphertext2_out),
    .ciphertext3_out (ciphertext3_out),
    .valid_out       (valid_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge and settle before sampling
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [127:0] pt, input logic [127:0] key);
    {plaintext0_in, plaintext1_in, plaintext2_in, plaintext3_in} = pt;
    {key0_in, key1_in, key2_in, key3_in} = key;
  endtask

  // Drive operands, pulse start across one edge (edge N)
  task automatic do_start(input logic [127:0] pt, input logic [127:0] key);
    set_inputs(pt, key);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  // Count edges after edge N until valid_out is seen, bounded
  task automatic wait_valid(input int already, output int cnt);
    cnt = already;
    while (!valid_out && cnt < c_MAX_WAIT) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    RST      = 1'b0;
    start_in = 1'b0;
    set_inputs('0, '0);

    // 1. Reset
    tick();
    tick();
    check("reset_valid", {127'd0, valid_out}, 128'd0);
    check("reset_ct", w_ct_all, 128'd0);
    RST = 1'b1;

    // 2. "Two One Nine Two" with intermediate values
    do_start(c_PT_A, c_KEY_A);
    check("t2_valid_after_start", {127'd0, valid_out}, 128'd0);
    tick();
    check("t2_round0_state", dut.r_state, c_R0_A);
    tick();
    check("t2_round_key1", dut.r_rkey, c_RK1_A);
    wait_valid(2, n);
    check("t2_latency", 128'(n), 128'd11);
    check("t2_ct", w_ct_all, c_CT_A);
    repeat (4) tick();
    check("t2_valid_hold", {127'd0, valid_out}, 128'd1);
    check("t2_ct_hold", w_ct_all, c_CT_A);

    // 3. FIPS-197 C.1; valid drops on the accepting edge
    do_start(c_PT_B, c_KEY_B);
    check("t3_valid_drop", {127'd0, valid_out}, 128'd0);
    wait_valid(0, n);
    check("t3_latency", 128'(n), 128'd11);
    check("t3_ct", w_ct_all, c_CT_B);

    // 4. Start while busy is ignored
    do_start(c_PT_A, c_KEY_A);
    repeat (4) tick();
    set_inputs(c_PT_B, c_KEY_B);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_valid(5, n);
    check("t4_latency", 128'(n), 128'd11);
    check("t4_ct", w_ct_all, c_CT_A);
    repeat (15) tick();
    check("t4_no_rerun_valid", {127'd0, valid_out}, 128'd1);
    check("t4_no_rerun_ct", w_ct_all, c_CT_A);

    // 5. Inputs change right after the start edge
    do_start(c_PT_A, c_KEY_A);
    set_inputs(c_PT_B, c_KEY_B);
    wait_valid(0, n);
    check("t5_latency", 128'(n), 128'd11);
    check("t5_ct", w_ct_all, c_CT_A);

    // 6. Reset mid-operation, then a fresh run
    do_start(c_PT_A, c_KEY_A);
    repeat (5) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("t6_reset_valid", {127'd0, valid_out}, 128'd0);
    check("t6_reset_ct", w_ct_all, 128'd0);
    repeat (12) tick();
    check("t6_aborted_no_valid", {127'd0, valid_out}, 128'd0);
    do_start(c_PT_B, c_KEY_B);
    wait_valid(0, n);
    check("t6_latency", 128'(n), 128'd11);
    check("t6_ct", w_ct_all, c_CT_B);

    // 7. Start held high restarts once back in IDLE
    set_inputs(c_PT_A, c_KEY_A);
    start_in = 1'b1;
    tick();
    wait_valid(0, n);
    check("t7_latency", 128'(n), 128'd11);
    check("t7_ct", w_ct_all, c_CT_A);
    tick();
    check("t7_restart_valid_drop", {127'd0, valid_out}, 128'd0);
    start_in = 1'b0;
    wait_valid(0, n);
    check("t7_restart_latency", 128'(n), 128'd11);
    check("t7_restart_ct", w_ct_all, c_CT_A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
